// File: rtl/ram_arb.sv
// ============================================================================
// Module      : ram_arb
// Description : Two-master round-robin arbiter in front of a single shared
//               RAM port. One transaction is outstanding at a time, carried
//               through a three-state FSM: IDLE (arbitrate and accept),
//               REQ (issue the registered command to the RAM) and
//               RSP (route the RAM response back to the granted master).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   mN_addr_i/data_i/sel_i/we_i  master N command (N = 0, 1)
//   mN_req_valid_i/req_ready_o   master N request handshake
//   mN_data_o                    master N read data (0 when not routed)
//   mN_rsp_valid_o/rsp_ready_i   master N response handshake
//   s_addr_o/data_o/sel_o/we_o   command toward the shared RAM
//   s_req_valid_o/req_ready_i    RAM request handshake
//   s_data_i                     RAM read data
//   s_rsp_valid_i/rsp_ready_o    RAM response handshake
// ============================================================================
`default_nettype none

module ram_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // master 0
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_data_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_req_valid_i,
  output logic            m0_req_ready_o,
  output logic [DW-1:0]   m0_data_o,
  output logic            m0_rsp_valid_o,
  input  logic            m0_rsp_ready_i,
  // master 1
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_data_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_req_valid_i,
  output logic            m1_req_ready_o,
  output logic [DW-1:0]   m1_data_o,
  output logic            m1_rsp_valid_o,
  input  logic            m1_rsp_ready_i,
  // shared RAM
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_data_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_req_valid_o,
  input  logic            s_req_ready_i,
  input  logic [DW-1:0]   s_data_i,
  input  logic            s_rsp_valid_i,
  output logic            s_rsp_ready_o
);

  localparam int SW = DW / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          gnt_q,   gnt_d;    // master owning the current transaction
  logic          last_q,  last_d;   // master granted most recently
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] data_q,  data_d;
  logic [SW-1:0] sel_q,   sel_d;
  logic          we_q,    we_d;

  logic w_any;      // at least one master requesting
  logic w_win;      // arbitration winner index
  logic w_rsp_rdy;  // rsp_ready of the granted master

  // Round-robin: on a tie the master that was not granted last wins,
  // otherwise the single requester wins.
  always_comb begin
    w_any     = m0_req_valid_i | m1_req_valid_i;
    w_win     = (m0_req_valid_i & m1_req_valid_i) ? ~last_q : m1_req_valid_i;
    w_rsp_rdy = gnt_q ? m1_rsp_ready_i : m0_rsp_ready_i;
  end

  // Next-state and command capture
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          gnt_d   = w_win;
          last_d  = w_win;
          addr_d  = w_win ? m1_addr_i : m0_addr_i;
          data_d  = w_win ? m1_data_i : m0_data_i;
          sel_d   = w_win ? m1_sel_i  : m0_sel_i;
          we_d    = w_win ? m1_we_i   : m0_we_i;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (s_req_ready_i) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (s_rsp_valid_i && w_rsp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_q resets to 1 so that master 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
    end
  end

  // The command registers only change on acceptance, so the RAM sees a
  // stable command for the whole REQ phase.
  assign s_addr_o = addr_q;
  assign s_data_o = data_q;
  assign s_sel_o  = sel_q;
  assign s_we_o   = we_q;

  // Handshake and response routing. Gated by rst so every output is 0
  // while reset is held, even though the FSM would otherwise be in IDLE.
  always_comb begin
    m0_req_ready_o = 1'b0;
    m1_req_ready_o = 1'b0;
    m0_rsp_valid_o = 1'b0;
    m1_rsp_valid_o = 1'b0;
    m0_data_o      = '0;
    m1_data_o      = '0;
    s_req_valid_o  = 1'b0;
    s_rsp_ready_o  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          m0_req_ready_o = w_any & ~w_win;
          m1_req_ready_o = w_any &  w_win;
        end
        ST_REQ: begin
          s_req_valid_o = 1'b1;
        end
        ST_RSP: begin
          if (gnt_q) begin
            m1_rsp_valid_o = s_rsp_valid_i;
            m1_data_o      = s_data_i;
            s_rsp_ready_o  = m1_rsp_ready_i;
          end else begin
            m0_rsp_valid_o = s_rsp_valid_i;
            m0_data_o      = s_data_i;
            s_rsp_ready_o  = m0_rsp_ready_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_arb.sv
// ============================================================================
// Module      : tb_ram_arb
// Description : Self-checking bench for ram_arb. A behavioural RAM drives the
//               slave side; a transaction-level reference model predicts
//               every output each cycle and the read data delivered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // master-side stimulus ([0] = m0, [1] = m1)
  logic [1:0][31:0] m_addr, m_data, m_do;
  logic [1:0][3:0]  m_sel;
  logic [1:0]       m_we, m_rv, m_rr, m_rdy, m_rspv;
  // slave-side
  logic [31:0] s_addr, s_dout, s_di;
  logic [3:0]  s_sel;
  logic        s_we, s_reqv, s_rr, s_rv, s_rspr;

  ram_arb #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_data[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_req_valid_i(m_rv[0]), .m0_req_ready_o(m_rdy[0]), .m0_data_o(m_do[0]),
    .m0_rsp_valid_o(m_rspv[0]), .m0_rsp_ready_i(m_rr[0]),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_data[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_req_valid_i(m_rv[1]), .m1_req_ready_o(m_rdy[1]), .m1_data_o(m_do[1]),
    .m1_rsp_valid_o(m_rspv[1]), .m1_rsp_ready_i(m_rr[1]),
    .s_addr_o(s_addr), .s_data_o(s_dout), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_req_valid_o(s_reqv), .s_req_ready_i(s_rr), .s_data_i(s_di),
    .s_rsp_valid_i(s_rv), .s_rsp_ready_o(s_rspr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // bench RAM (environment) and reference memory (model view)
  logic [31:0] ram  [64];
  logic [31:0] refm [64];
  logic        ram_pend = 1'b0;
  logic [31:0] ram_pdata = '0;
  int          ram_lat = 0;
  bit          rnd_mode = 1'b0;

  // transaction-level reference model
  bit          t_valid = 0, t_issued = 0, t_owner = 0, t_we = 0;
  logic [31:0] t_addr = '0, t_data = '0, t_exp = '0;
  logic [3:0]  t_sel = '0;
  bit          m_last = 1;

  // values sampled in the most recent step
  logic [1:0]       smp_rdy, smp_rspv;
  logic [1:0][31:0] smp_mdo;
  logic             smp_srv, smp_swe, smp_srr;
  logic [31:0]      smp_saddr, smp_sdata;
  logic [3:0]       smp_ssel;

  typedef struct {
    logic [1:0] req;
    logic [1:0] rdy;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic mem_init(input int idx, input logic [31:0] v);
    ram[idx]  = v;
    refm[idx] = v;
  endtask

  // One clock cycle: drive RAM response, sample, check, advance model.
  task automatic step();
    logic [1:0]       e_rdy, e_rspv;
    logic [1:0][31:0] e_mdo;
    logic             e_srv, e_srr;
    int               w, idx;
    @(negedge clk);
    s_rv = ram_pend && (ram_lat == 0);
    s_di = s_rv ? ram_pdata : $urandom;
    #1;
    smp_rdy = m_rdy; smp_rspv = m_rspv; smp_mdo = m_do;
    smp_srv = s_reqv; smp_saddr = s_addr; smp_sdata = s_dout;
    smp_ssel = s_sel; smp_swe = s_we; smp_srr = s_rspr;

    e_rdy = 2'b00; e_rspv = 2'b00; e_mdo = '0; e_srv = 0; e_srr = 0;
    w = (m_rv == 2'b11) ? (m_last ? 0 : 1) : (m_rv[1] ? 1 : 0);
    if (!t_valid) begin
      if (m_rv != 2'b00) e_rdy[w] = 1'b1;
    end else if (!t_issued) begin
      e_srv = 1'b1;
    end else begin
      e_rspv[t_owner] = s_rv;
      e_mdo[t_owner]  = s_di;
      e_srr           = m_rr[t_owner];
    end
    chk("req_ready", smp_rdy, e_rdy);
    chk("s_req_valid", smp_srv, e_srv);
    if (e_srv) chk("s_cmd", {smp_saddr, smp_sdata, smp_ssel, smp_swe},
                   {t_addr, t_data, t_sel, t_we});
    chk("rsp_hs", {smp_rspv, smp_srr}, {e_rspv, e_srr});
    chk("m_data", smp_mdo, e_mdo);

    // reference model advance
    if (!t_valid) begin
      if (m_rv != 2'b00) begin
        t_valid = 1; t_issued = 0; t_owner = w[0]; m_last = w[0];
        t_addr = m_addr[w]; t_data = m_data[w]; t_sel = m_sel[w]; t_we = m_we[w];
        idx = int'(t_addr[7:2]);
        if (t_we) refm[idx] = merge(refm[idx], t_data, t_sel);
        else      t_exp = refm[idx];
      end
    end else if (!t_issued) begin
      if (s_rr) t_issued = 1;
    end else if (s_rv && m_rr[t_owner]) begin
      if (!t_we) chk("read_data", smp_mdo[t_owner], t_exp);
      t_valid = 0;
    end

    // RAM environment advance, reacting to what the DUT presented
    if (smp_srv && s_rr) begin
      idx = int'(smp_saddr[7:2]);
      if (smp_swe) ram[idx] = merge(ram[idx], smp_sdata, smp_ssel);
      ram_pdata = ram[idx];
      ram_pend  = 1'b1;
      ram_lat   = rnd_mode ? int'($urandom_range(0, 2)) : 0;
    end else if (ram_pend && s_rv && smp_srr) begin
      ram_pend = 1'b0;
    end else if (ram_pend && ram_lat > 0) begin
      ram_lat--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    t_valid = 0; t_issued = 0; m_last = 1;
    ram_pend = 0; ram_lat = 0;
  endtask

  task automatic do_reset();
    m_rv = 2'b00;
    rst  = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_addr = '0; m_data = '0; m_sel = '1; m_we = '0; m_rv = 2'b11; m_rr = 2'b11;
    s_rr = 1'b1; s_rv = 1'b1; s_di = 32'hCAFEF00D;
    for (int i = 0; i < 64; i++) mem_init(i, $urandom);
    tbl[0] = '{2'b11, 2'b01}; tbl[1] = '{2'b11, 2'b10}; tbl[2] = '{2'b10, 2'b10};
    tbl[3] = '{2'b11, 2'b01}; tbl[4] = '{2'b01, 2'b01}; tbl[5] = '{2'b11, 2'b10};
    tbl[6] = '{2'b00, 2'b00}; tbl[7] = '{2'b10, 2'b10}; tbl[8] = '{2'b11, 2'b01};

    // Reset state: everything 0 even with requests and a response pending
    #2;
    chk("reset_outputs", {m_rdy, m_rspv, m_do, s_reqv, s_rspr, s_addr, s_sel, s_we},
        '0);
    s_rv = 1'b0;
    do_reset();

    // Single read
    mem_init(4, 32'h12345678);
    m_addr[0] = 32'h10; m_we[0] = 0; m_rv = 2'b01;
    step(); chk("rd_c0_ready", smp_rdy, 2'b01);
    m_rv = 2'b00;
    step(); chk("rd_c1_issue", {smp_srv, smp_saddr}, {1'b1, 32'h10});
    step(); chk("rd_c2_rsp", {smp_rspv[0], smp_mdo[0]}, {1'b1, 32'h12345678});

    // Simultaneous requests from reset: m0, m1, m0, m1 every 3 cycles
    do_reset();
    m_we = 2'b00; m_addr[0] = 32'h4; m_addr[1] = 32'h8; m_rv = 2'b11;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i % 3 == 0) chk("tie_grant", smp_rdy, ((i / 3) % 2) ? 2'b10 : 2'b01);
      else            chk("tie_busy", smp_rdy, 2'b00);
    end
    m_rv = 2'b00;

    // Masked write then read-back by m1
    mem_init(8, 32'hAAAAAAAA);
    m_addr[1] = 32'h20; m_data[1] = 32'hDEADBEEF; m_sel[1] = 4'b0011; m_we[1] = 1;
    m_rv = 2'b10;
    step(); m_rv = 2'b00;
    step(); chk("wr_issue_sel", {smp_srv, smp_ssel, smp_swe}, {1'b1, 4'b0011, 1'b1});
    step(); chk("wr_rsp", smp_rspv, 2'b10);
    m_we[1] = 0; m_sel[1] = 4'b1111; m_rv = 2'b10;
    step(); m_rv = 2'b00;
    step();
    step(); chk("rd_after_wr", {smp_rspv[1], smp_mdo[1]}, {1'b1, 32'hAAAABEEF});

    // Backpressure on issue and on response, m1 kept waiting
    m_addr[0] = 32'h30; m_we[0] = 0; m_rv = 2'b01;
    step();
    m_rv = 2'b10; s_rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_req_hold", {smp_srv, smp_saddr, smp_rdy}, {1'b1, 32'h30, 2'b00});
    end
    s_rr = 1'b1;
    step();
    m_rr[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_rsp_hold", {smp_rspv, smp_srr, smp_rdy}, {2'b01, 1'b0, 2'b00});
    end
    m_rr[0] = 1'b1;
    step(); chk("bp_rsp_done", {smp_rspv, smp_srr}, {2'b01, 1'b1});
    step(); chk("bp_m1_now", smp_rdy, 2'b10);
    m_rv = 2'b00;
    step(); step();

    // Reset pulsed while in RSP
    m_addr[0] = 32'h3C; m_rv = 2'b01; m_rr = 2'b00;
    step(); m_rv = 2'b00;
    step();
    step(); chk("rstm_in_rsp", smp_rspv, 2'b01);
    @(negedge clk);
    m_rr = 2'b11; m_rv = 2'b10; s_rv = 1'b1; s_di = ram_pdata;
    #1;
    rst = 1'b1;
    #1;
    chk("rstm_zero", {m_rdy, m_rspv, m_do, s_reqv, s_rspr, s_addr, s_dout, s_sel, s_we},
        '0);
    model_reset();
    s_rv = 1'b0;
    @(posedge clk); #1;
    chk("rstm_no_rsp", {m_rspv, s_rspr}, 3'b000);
    @(negedge clk);
    m_rv = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;
    m_rv = 2'b11;
    step(); chk("rstm_tie_m0", smp_rdy, 2'b01);
    m_rv = 2'b00;
    step(); step();

    // Table of arbitration patterns from reset
    do_reset();
    for (int i = 0; i < 9; i++) begin
      m_rv = tbl[i].req;
      step();
      chk("tbl_grant", smp_rdy, tbl[i].rdy);
      m_rv = 2'b00;
      if (tbl[i].rdy != 2'b00) begin
        step(); step();
      end
    end

    // Randomized traffic against the reference model
    rnd_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        m_addr[k] = $urandom;
        m_data[k] = $urandom;
        m_sel[k]  = 4'($urandom);
        m_we[k]   = 1'($urandom);
        m_rv[k]   = ($urandom_range(0, 2) != 0);
        m_rr[k]   = ($urandom_range(0, 3) != 0);
      end
      s_rr = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
